// File: rtl/man_jump_physics_pkg.sv
// jump_pkg: shared definitions for the jump physics block.
//   - game FSM state codes seen on the 'state' input
//   - physics datapath widths
//   - local FSM state enum
//   - saturating unsigned add used for horizontal displacement
package jump_pkg;

  localparam logic [2:0] ACCU = 3'd3;
  localparam logic [2:0] JUMP = 3'd4;

  localparam int H_W = 16;
  localparam int V_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_FLY,
    S_DONE,
    S_HOLD
  } jump_state_e;

  function automatic logic [H_W-1:0] sat_add(input logic [H_W-1:0] a,
                                             input logic [H_W-1:0] b);
    logic [H_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[H_W] ? {H_W{1'b1}} : s[H_W-1:0];
  endfunction

endpackage

// File: rtl/man_jump_physics_integrator.sv
// jump_integrator: per-tick height / vertical-velocity / displacement datapath.
//   clk, rst     : clock, async active-high reset
//   i_load       : latch v_init into vy/vx, clear h and dx
//   i_v_init     : initial velocity, unsigned
//   i_step       : integrate one frame tick
//   i_clear_h    : abort, force h to 0, hold everything else
//   o_h, o_dx    : registered height and horizontal displacement
//   o_land       : the step presented this cycle would land (next_h <= 0)
import jump_pkg::*;

module jump_integrator #(
  parameter int GRAVITY  = 1,
  parameter int VX_SHIFT = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_load,
  input  logic [V_W-1:0] i_v_init,
  input  logic           i_step,
  input  logic           i_clear_h,
  output logic [H_W-1:0] o_h,
  output logic [H_W-1:0] o_dx,
  output logic           o_land
);

  logic        [H_W-1:0] r_h;
  logic        [H_W-1:0] r_dx;
  logic signed [H_W-1:0] r_vy;
  logic        [V_W-1:0] r_vx;

  // h is non-negative, vy is signed: one extra bit keeps the sum exact
  logic signed [H_W:0] w_next_h;
  logic                w_land;

  assign w_next_h = $signed({1'b0, r_h}) + $signed({r_vy[H_W-1], r_vy});
  assign w_land   = w_next_h[H_W] || (w_next_h == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h  <= '0;
      r_dx <= '0;
      r_vy <= '0;
      r_vx <= '0;
    end else if (i_clear_h) begin
      r_h <= '0;
    end else if (i_load) begin
      r_vy <= $signed({{(H_W-V_W){1'b0}}, i_v_init});
      r_vx <= i_v_init >> VX_SHIFT;
      r_h  <= '0;
      r_dx <= '0;
    end else if (i_step) begin
      r_h  <= w_land ? '0 : w_next_h[H_W-1:0];
      r_vy <= r_vy - H_W'(GRAVITY);
      r_dx <= sat_add(r_dx, {{(H_W-V_W){1'b0}}, r_vx});
    end
  end

  assign o_h    = r_h;
  assign o_dx   = r_dx;
  assign o_land = w_land;

endmodule

// File: rtl/man_jump_physics.sv
// man_jump_physics: jump motion integrator for the player character.
// Latches the initial velocity on entry to the jump game state, integrates
// height under constant gravity and horizontal displacement per frame tick,
// and pulses o_jump_done for one cycle on landing.
//   clk_machine, rst_machine : clock, async active-high reset
//   state                    : game FSM state code
//   i_frame_tick             : one-cycle pulse per video frame
//   i_jump_v_init            : initial velocity from the charge stage
//   o_man_h / o_man_dx       : height above ground / displacement since launch
//   o_airborne               : high in LAUNCH and FLY
//   o_jump_done              : one-cycle landing pulse
import jump_pkg::*;

module man_jump_physics #(
  parameter int         GRAVITY   = 1,
  parameter int         VX_SHIFT  = 2,
  parameter logic [2:0] JUMP_CODE = JUMP
) (
  input  logic           clk_machine,
  input  logic           rst_machine,
  input  logic [2:0]     state,
  input  logic           i_frame_tick,
  input  logic [V_W-1:0] i_jump_v_init,
  output logic [H_W-1:0] o_man_h,
  output logic [H_W-1:0] o_man_dx,
  output logic           o_airborne,
  output logic           o_jump_done
);

  jump_state_e r_state;
  logic        r_airborne;
  logic        r_done;

  logic w_in_jump;
  logic w_load;
  logic w_step;
  logic w_abort;
  logic w_land;

  assign w_in_jump = (state == JUMP_CODE);
  // Leaving the jump state beats everything, including a landing tick
  assign w_abort   = ((r_state == S_LAUNCH) || (r_state == S_FLY)) && !w_in_jump;
  assign w_load    = (r_state == S_LAUNCH) && w_in_jump;
  assign w_step    = (r_state == S_FLY) && w_in_jump && i_frame_tick;

  jump_integrator #(
    .GRAVITY  (GRAVITY),
    .VX_SHIFT (VX_SHIFT)
  ) u_integ (
    .clk       (clk_machine),
    .rst       (rst_machine),
    .i_load    (w_load),
    .i_v_init  (i_jump_v_init),
    .i_step    (w_step),
    .i_clear_h (w_abort),
    .o_h       (o_man_h),
    .o_dx      (o_man_dx),
    .o_land    (w_land)
  );

  always_ff @(posedge clk_machine or posedge rst_machine) begin
    if (rst_machine) begin
      r_state    <= S_IDLE;
      r_airborne <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_in_jump) begin
            r_state    <= S_LAUNCH;
            r_airborne <= 1'b1;
          end
        end
        S_LAUNCH: begin
          if (!w_in_jump) begin
            r_state    <= S_IDLE;
            r_airborne <= 1'b0;
          end else begin
            r_state <= S_FLY;
          end
        end
        S_FLY: begin
          if (!w_in_jump) begin
            r_state    <= S_IDLE;
            r_airborne <= 1'b0;
          end else if (i_frame_tick && w_land) begin
            r_state    <= S_DONE;
            r_airborne <= 1'b0;
            r_done     <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_HOLD;
        end
        S_HOLD: begin
          // Must see state leave the jump code before another launch
          if (!w_in_jump) r_state <= S_IDLE;
        end
        default: begin
          r_state    <= S_IDLE;
          r_airborne <= 1'b0;
        end
      endcase
    end
  end

  assign o_airborne  = r_airborne;
  assign o_jump_done = r_done;

endmodule

// File: doc/man_jump_physics.md
# man_jump_physics

Vertical/horizontal motion integrator for the player character during a jump. It sits directly downstream of the charge-velocity stage. It latches the 8-bit initial jump velocity when the game FSM enters the jump state, then integrates height under constant gravity and horizontal displacement once per frame tick. On landing it issues the one-cycle `o_jump_done` pulse that clears the upstream charge counter and advances the game FSM.

## Interface
- `GRAVITY`, 1: height-velocity decrement per frame tick (unsigned, ≥1).
- `VX_SHIFT`, 2: horizontal speed = `v_init >> VX_SHIFT`.
- `JUMP_CODE`, 3'd4: game-state code meaning "jumping".
- `clk_machine` in 1: main clock (25 MHz).
- `rst_machine` in 1: asynchronous reset, active-high.
- `state` in 3: current game FSM state code.
- `i_frame_tick` in 1: one-cycle pulse per video frame.
- `i_jump_v_init` in 8: initial velocity from the charge stage, unsigned.
- `o_man_h` out 16: height above landing surface, unsigned, 0 = on ground.
- `o_man_dx` out 16: horizontal displacement since launch, unsigned.
- `o_airborne` out 1: high while integrating.
- `o_jump_done` out 1: one-cycle landing pulse.

## Operation
- FSM states and transitions:
  - IDLE → LAUNCH when `state == JUMP_CODE`.
  - LAUNCH → FLY, unconditionally after 1 cycle.
  - FLY → DONE on the landing tick.
  - DONE → HOLD, unconditionally after 1 cycle.
  - HOLD → IDLE when `state != JUMP_CODE`.
- LAUNCH:
  - Latch `vy = {8'b0, i_jump_v_init}` as a signed 16-bit value (positive = upward).
  - Latch `vx = i_jump_v_init >> VX_SHIFT`.
  - Clear `h` and `dx`.
- FLY, on each `i_frame_tick`:
  - `next_h = h + vy`, computed signed 17-bit.
  - If `next_h <= 0`: landing. Set `h <= 0`, go to DONE.
  - Otherwise `h <= next_h`.
  - In both cases `vy <= vy - GRAVITY` and `dx <= dx + vx`, with `dx` saturating at 16'hFFFF.
- DONE: `o_jump_done = 1` for exactly this cycle. `h` and `dx` are held.
- HOLD: outputs are held and ticks are ignored. A new launch is not possible until `state` leaves `JUMP_CODE` and returns.
- Abort: if `state != JUMP_CODE` while in LAUNCH or FLY, go to IDLE, force `h <= 0`, hold `dx`, and do not pulse done.
- `o_airborne` is high exactly in LAUNCH and FLY.
- `v_init = 0`: the first tick lands (`next_h = 0`), giving a done pulse with `dx = 0`.
- Range:
  - Maximum peak height for `v_init = 255`, `GRAVITY = 1` is 32640, which fits 16 bits.
  - Larger values are not reachable with legal parameters. No height saturation is required.

## Timing
- Reset values: all outputs 0, FSM in IDLE, `vy`/`vx`/`h`/`dx` all 0.
- Reset mid-flight returns the block to IDLE immediately.
- Launch latency: `state` becomes `JUMP_CODE` in cycle N → LAUNCH in N+1 → FLY in N+2.
  - Ticks arriving in cycles N and N+1 are ignored.
  - `i_jump_v_init` is sampled in cycle N+1. Upstream holds it stable throughout the jump state.
- Tick processing: a tick in FLY at cycle T updates `o_man_h`/`o_man_dx`, visible at T+1.
  - On a landing tick, `o_jump_done` is high at T+1 only.
  - `o_airborne` falls at T+1.
- Simultaneous landing tick and state leaving `JUMP_CODE`: the abort takes priority and no done pulse is issued.
- All outputs are registered; there are no combinational paths from input to output.

## Structure
- Shared package `jump_pkg`:
  - Game state codes (`ACCU = 3'd3`, `JUMP = 3'd4`).
  - Physics widths (`H_W = 16`, `V_W = 8`).
  - The FSM state enum for this block.
- One natural sub-module, `jump_integrator`: the per-tick `h`/`vy`/`dx` datapath with the landing compare.
- The FSM stays in the top module.
- Expected size: 150–250 lines of RTL.

## Test plan
- `v_init = 4`, `GRAVITY = 1`, `VX_SHIFT = 2`, nine ticks:
  - `o_man_h` sequence 4, 7, 9, 10, 10, 9, 7, 4, 0.
  - `o_jump_done` is a single pulse after tick 9.
  - `o_man_dx = 9`.
- `v_init = 0`: first tick → `h = 0`, done pulses once, `dx = 0`.
- `v_init = 4`, `state` changes to 3'd3 after tick 3 (`h = 9`) → `h = 0`, `o_airborne = 0`, no done pulse, IDLE.
- After landing, `state` stays `JUMP_CODE` for 20 further ticks → no relaunch, no second done pulse, `h = 0` and `dx` held.
  - `state` then goes 3'd3 → 3'd4 with `v_init = 2` → a new jump, `h` sequence 2, 3, 3, 2, 0.
- `v_init = 255`:
  - Peak `h = 32640`.
  - Landing after 511 ticks.
  - `dx = 511 × 63 = 32193`.
  - No wrap.
- `rst_machine` asserted mid-FLY, asynchronously between clock edges → all outputs 0 immediately.
  - After release, the next jump-state entry launches normally.
